store_pack: RTL and testbench
=============================

Name: store_pack

Overview:
- MEM-stage store packer for the pipelined MIPS core; the write-side counterpart of immediate/load extension.
- Takes a 32-bit register value and a store width (sw/sh/sb) from EX/MEM.
- Narrows and replicates the value onto the word-wide data-memory bus with byte enables.
- Holds a one-entry buffer with a valid/ready handshake toward EX/MEM and a req/ack handshake toward data memory; flags misaligned stores.

Parameters:
- ADDR_W, 32, byte-address width; bits [1:0] select the byte lane.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- st_valid  in  1  store request from EX/MEM
- st_ready  out  1  packer can accept a request this cycle
- st_op  in  2  00=sw, 01=sh, 10=sb, 11=reserved
- st_addr  in  ADDR_W  byte address
- st_data  in  32  rt register value
- mem_req  out  1  write request to data memory
- mem_ack  in  1  memory accepted the write this cycle
- mem_addr  out  ADDR_W  word address, bits [1:0] forced to 00
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- err_ades  out  1  one-cycle pulse: misaligned or reserved store rejected
- err_addr  out  ADDR_W  address of the last rejected store
- store_cnt  out  16  completed-store count (optional feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, err_ades=0, err_addr=0, store_cnt=0.
  - A pending request is dropped, never issued.
- States:
  - IDLE: buffer empty.
  - BUSY: buffer holds one store; mem_req=1.
- st_ready = (state==IDLE) | mem_ack. Combinational; never depends on st_valid.
- Accept occurs when st_valid & st_ready at a clock edge.
  - Legal accept: the buffer loads on that edge; mem_req=1 from the next cycle. Latency is 1 cycle.
  - Illegal accept: nothing is loaded and the state is unchanged.
- Packing for a legal store, with a = st_addr[1:0]:
  - sw: wdata=st_data, be=1111.
  - sh: wdata={2{st_data[15:0]}}, be = a[1] ? 1100 : 0011.
  - sb: wdata={4{st_data[7:0]}}, be = 0001 << a.
- Misalignment rules, applied at accept:
  - sw with a!=00, sh with a[0]=1, or st_op=11 is illegal.
  - Illegal store: no buffer load; err_ades=1 for exactly one cycle after the accept edge; err_addr=st_addr is registered and held until the next error.
- Transitions:
  - IDLE, legal accept -> BUSY.
  - BUSY, mem_ack=1, no legal accept -> IDLE (mem_req=0 next cycle).
  - BUSY, mem_ack=1 with a legal accept in the same cycle -> stays BUSY with the new entry (back-to-back, no bubble).
  - BUSY, mem_ack=0: all mem_* outputs hold stable and st_ready=0.
- Simultaneous events:
  - mem_ack together with an illegal accept: the buffer drains to IDLE and err_ades pulses.
  - mem_ack while IDLE is ignored.
- mem_addr = {st_addr[ADDR_W-1:2], 2'b00}.
- Outputs are registered except st_ready.

Optional Feature:
- STORE_PACK_STAT_EN defined:
  - store_cnt increments on each cycle with mem_req & mem_ack.
  - Saturates at 16'hFFFF; no wrap.
  - Cleared only by reset.
- STORE_PACK_STAT_EN undefined:
  - store_cnt is tied to 16'h0000 and no counter logic is generated.
  - All other behaviour is identical.

Test Plan:
- sb, addr=0x00000013, data=0x12345678, ack on first req cycle:
  - Next cycle: mem_req=1, mem_addr=0x10, mem_wdata=0x78787878, mem_be=1000.
  - Following cycle: mem_req=0.
- sh, addr=0x22, data=0xCAFEBEEF, ack delayed 3 cycles:
  - mem_wdata=0xBEEFBEEF and mem_be=1100 are held stable for 3 cycles.
  - st_ready=0 until the ack cycle.
- Back-to-back: sw to 0x40 (data 0xA5A5A5A5) then sb to 0x41 (data 0x3C) presented in the ack cycle:
  - No idle cycle between requests.
  - Second request: mem_be=0010, mem_wdata=0x3C3C3C3C.
- sw to 0x102 and st_op=11 to 0x200:
  - err_ades pulses once for each; err_addr=0x102 then 0x200.
  - mem_req never asserts; st_ready stays 1.
- reset driven low mid-BUSY, asynchronously between edges:
  - mem_req, mem_be, mem_wdata and err_ades go to 0 immediately.
  - After reset is released, the next legal store issues normally.
- With STORE_PACK_STAT_EN defined, issue 5 acked stores:
  - store_cnt=5.
  - With the counter preloaded near saturation (force to 0xFFFE), two further acks leave store_cnt=0xFFFF.
- Without STORE_PACK_STAT_EN: store_cnt=0 throughout.

Source files
------------

// File: rtl/store_pack_if.sv
// Store packer bus bundle: EX/MEM-side valid/ready request channel and
// data-memory-side req/ack write channel.
// slave  = the packer (accepts stores, drives memory writes)
// master = the environment (presents stores, acknowledges memory writes)
interface store_pack_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [1:0]        st_op;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;

    logic              mem_req;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;

    modport slave (
        input  st_valid, st_op, st_addr, st_data, mem_ack,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output st_valid, st_op, st_addr, st_data, mem_ack,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_pack.sv
// MEM-stage store packer: narrows/replicates a register value onto the
// word-wide data bus with byte enables, buffers one store between the
// EX/MEM handshake and the memory handshake, and flags misaligned or
// reserved stores.
// Optional completed-store counter: define STORE_PACK_STAT_EN.
module store_pack #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    store_pack_if.slave       bus,
    output logic              err_ades,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       store_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  lane;
    logic        legal;
    logic        accept;
    logic        load;
    logic [31:0] wdata_d;
    logic [3:0]  be_d;

    assign lane = bus.st_addr[1:0];

    // Legality check and lane packing for the store presented this cycle
    always_comb begin
        legal   = 1'b0;
        wdata_d = '0;
        be_d    = '0;
        case (bus.st_op)
            2'b00: begin
                legal   = (lane == 2'b00);
                wdata_d = bus.st_data;
                be_d    = '1;
            end
            2'b01: begin
                legal   = ~lane[0];
                wdata_d = {2{bus.st_data[15:0]}};
                be_d    = lane[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal   = 1'b1;
                wdata_d = {4{bus.st_data[7:0]}};
                be_d    = 4'b0001 << lane;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    assign bus.st_ready = (state_q == IDLE) | bus.mem_ack;
    assign accept       = bus.st_valid & bus.st_ready;
    assign load         = accept & legal;

    // Next-state: a legal accept always (re)fills the buffer, which also
    // covers the back-to-back case of an ack and a new store together
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) state_d = BUSY;
            end
            BUSY: begin
                if (load)             state_d = BUSY;
                else if (bus.mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign bus.mem_req = (state_q == BUSY);

    // Buffer entry: loaded only on a legal accept, held otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else if (load) begin
            bus.mem_addr  <= {bus.st_addr[ADDR_W-1:2], 2'b00};
            bus.mem_wdata <= wdata_d;
            bus.mem_be    <= be_d;
        end
    end

    // Rejected-store pulse and sticky address of the last rejection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_ades <= 1'b0;
            err_addr <= '0;
        end else begin
            err_ades <= accept & ~legal;
            if (accept & ~legal) err_addr <= bus.st_addr;
        end
    end

`ifdef STORE_PACK_STAT_EN
    logic [15:0] cnt_q;

    // Saturating count of completed memory writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    cnt_q <= '0;
        else if (bus.mem_req && bus.mem_ack && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end

    assign store_cnt = cnt_q;
`else
    assign store_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_store_pack.sv
// Self-checking bench for store_pack: directed test-plan steps followed by
// randomized traffic, all checked against a transaction-level model.
// Build with +define+STORE_PACK_STAT_EN to exercise the store counter.
module tb_store_pack;

    localparam int unsigned AW = 32;

    logic        clk;
    logic        reset;
    logic        err_ades;
    logic [31:0] err_addr;
    logic [15:0] store_cnt;

    int unsigned n_assert;
    int unsigned n_fail;

    store_pack_if #(.ADDR_W(AW)) sif ();

    store_pack #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (sif.slave),
        .err_ades (err_ades),
        .err_addr (err_addr),
        .store_cnt(store_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    bit          m_busy;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    bit          m_err;
    logic [31:0] m_err_addr;
    logic [15:0] m_cnt;
`ifdef STORE_PACK_STAT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    function automatic bit m_legal(input logic [1:0] op, input logic [1:0] a);
        if (op == 2'd3) return 1'b0;
        if (op == 2'd0 && a != 2'd0) return 1'b0;
        if (op == 2'd1 && a[0]) return 1'b0;
        return 1'b1;
    endfunction

    // Store of `size` bytes at lane `a`: each lane i carries data byte
    // (i mod size); lanes a..a+size-1 are enabled.
    task automatic m_pack(input logic [1:0] op, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] w, output logic [3:0] be);
        int unsigned size;
        size = (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : 1;
        w  = '0;
        be = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w[8*i +: 8] = d[8*(i % size) +: 8];
            be[i]       = (i >= a) && (i < a + size);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_addr = '0; m_wdata = '0; m_be = '0;
        m_err = 0; m_err_addr = '0; m_cnt = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, sif.mem_req}, {31'd0, m_busy});
        if (m_busy) begin
            chk({tag, "_addr"},  sif.mem_addr, m_addr);
            chk({tag, "_wdata"}, sif.mem_wdata, m_wdata);
            chk({tag, "_be"},    {28'd0, sif.mem_be}, {28'd0, m_be});
        end
        chk({tag, "_err"},     {31'd0, err_ades}, {31'd0, m_err});
        chk({tag, "_erraddr"}, err_addr, m_err_addr);
        chk({tag, "_cnt"},     {16'd0, store_cnt}, {16'd0, m_cnt});
    endtask

    // One clock cycle: drive at negedge, check ready, advance model at the
    // edge, check registered outputs 1 time unit later.
    task automatic step(input string tag, input bit v, input logic [1:0] op,
                        input logic [31:0] addr, input logic [31:0] data, input bit ack);
        bit exp_ready;
        logic [31:0] w;
        logic [3:0]  be;
        @(negedge clk);
        sif.st_valid = v; sif.st_op = op; sif.st_addr = addr; sif.st_data = data;
        sif.mem_ack = ack;
        #1;
        exp_ready = !m_busy || ack;
        chk({tag, "_ready"}, {31'd0, sif.st_ready}, {31'd0, exp_ready});
        @(posedge clk);
        if (m_busy && ack) begin
            m_busy = 0;
            if (CNT_EN && m_cnt != 16'hFFFF) m_cnt++;
        end
        m_err = 0;
        if (v && exp_ready) begin
            if (m_legal(op, addr[1:0])) begin
                m_pack(op, addr[1:0], data, w, be);
                m_busy = 1; m_addr = {addr[31:2], 2'b00}; m_wdata = w; m_be = be;
            end else begin
                m_err = 1; m_err_addr = addr;
            end
        end
        #1;
        chk_outputs(tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b0;
        sif.st_valid = 0; sif.st_op = '0; sif.st_addr = '0; sif.st_data = '0; sif.mem_ack = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {31'd0, sif.mem_req}, 32'd0);
        chk("rst_addr",  sif.mem_addr, 32'd0);
        chk("rst_wdata", sif.mem_wdata, 32'd0);
        chk("rst_be",    {28'd0, sif.mem_be}, 32'd0);
        chk("rst_err",   {31'd0, err_ades}, 32'd0);
        chk("rst_erra",  err_addr, 32'd0);
        chk("rst_cnt",   {16'd0, store_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // sb to 0x13, acked on the first request cycle
        step("sb13", 1, 2'b10, 32'h13, 32'h12345678, 0);
        chk("tp1_addr",  sif.mem_addr, 32'h10);
        chk("tp1_wdata", sif.mem_wdata, 32'h78787878);
        chk("tp1_be",    {28'd0, sif.mem_be}, 32'b1000);
        step("sb13_ack", 0, 2'b00, 32'h0, 32'h0, 1);
        chk("tp1_drain", {31'd0, sif.mem_req}, 32'd0);

        // sh to 0x22, ack delayed
        step("sh22", 1, 2'b01, 32'h22, 32'hCAFEBEEF, 0);
        for (int i = 0; i < 2; i++) begin
            step("sh22_wait", 1, 2'b10, 32'h99, 32'h11, 0);
            chk("tp2_wdata", sif.mem_wdata, 32'hBEEFBEEF);
            chk("tp2_be",    {28'd0, sif.mem_be}, 32'b1100);
        end
        step("sh22_ack", 0, 2'b00, 32'h0, 32'h0, 1);

        // back-to-back: sw 0x40 then sb 0x41 in the ack cycle
        step("sw40", 1, 2'b00, 32'h40, 32'hA5A5A5A5, 0);
        step("sb41", 1, 2'b10, 32'h41, 32'h3C, 1);
        chk("tp3_req",   {31'd0, sif.mem_req}, 32'd1);
        chk("tp3_be",    {28'd0, sif.mem_be}, 32'b0010);
        chk("tp3_wdata", sif.mem_wdata, 32'h3C3C3C3C);
        step("sb41_ack", 0, 2'b00, 32'h0, 32'h0, 1);

        // misaligned sw and reserved op
        step("sw102", 1, 2'b00, 32'h102, 32'h1, 0);
        chk("tp4_erra1", err_addr, 32'h102);
        step("op3_200", 1, 2'b11, 32'h200, 32'h2, 0);
        chk("tp4_erra2", err_addr, 32'h200);
        chk("tp4_err2",  {31'd0, err_ades}, 32'd1);
        step("err_idle", 0, 2'b00, 32'h0, 32'h0, 0);
        chk("tp4_pulse", {31'd0, err_ades}, 32'd0);

        // async reset while BUSY
        step("pre_rst", 1, 2'b00, 32'h80, 32'hDEADBEEF, 0);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_req",   {31'd0, sif.mem_req}, 32'd0);
        chk("arst_be",    {28'd0, sif.mem_be}, 32'd0);
        chk("arst_wdata", sif.mem_wdata, 32'd0);
        chk("arst_err",   {31'd0, err_ades}, 32'd0);
        m_reset();
        sif.st_valid = 0; sif.mem_ack = 0;
        @(negedge clk);
        reset = 1'b1;
        step("post_rst", 1, 2'b01, 32'h86, 32'h00005A5A, 0);
        chk("post_rst_wdata", sif.mem_wdata, 32'h5A5A5A5A);
        step("post_rst_ack", 0, 2'b00, 32'h0, 32'h0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rnd", $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom_range(0, 1) == 1);
        end
        step("rnd_flush", 0, 2'b00, 32'h0, 32'h0, 1);

`ifdef STORE_PACK_STAT_EN
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        sif.st_valid = 0; sif.mem_ack = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("cnt_st", 1, 2'b00, 32'(i * 4), 32'(i), 0);
            step("cnt_ack", 0, 2'b00, 32'h0, 32'h0, 1);
        end
        chk("cnt5", {16'd0, store_cnt}, 32'd5);
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 2; i++) begin
            step("sat_st", 1, 2'b10, 32'h7, 32'hFF, 0);
            step("sat_ack", 0, 2'b00, 32'h0, 32'h0, 1);
        end
        chk("cnt_sat", {16'd0, store_cnt}, 32'hFFFF);
`else
        chk("cnt_off", {16'd0, store_cnt}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
